// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable width, parity and stop bits.
// Majority-vote sampling, glitch-rejecting start, framing/parity flags, break detect.
module uart_rx_cfg #(
  parameter int unsigned DIV    = 16,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PARITY = 0,
  parameter int unsigned STOPS  = 1
) (
  input  logic             reset,
  input  logic             clock,
  input  logic             rx,
  output logic             rts,
  output logic [WIDTH-1:0] out,
  output logic             put,
  output logic             frame_err,
  output logic             parity_err,
  output logic             brk
);

  localparam int unsigned CW = $clog2(DIV + 1);
  localparam int unsigned IW = 4;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_S0   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(DIV / 2);
  localparam logic [CW-1:0] C_DEC  = CW'(DIV / 2 + 1);

  typedef enum logic [2:0] {HUNT, IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state, state_n;
  logic             rs_meta, rs;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic             s0, s0_n, s1, s1_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             zero_acc, zero_acc_n;
  logic             fe_acc, fe_acc_n;
  logic             par_bad, par_bad_n;
  logic [WIDTH-1:0] out_n;
  logic             put_n, frame_err_n, parity_err_n, brk_n, rts_n;

  logic maj, dec, wrap, last_data, last_stop, fe_f, zero_f;

  assign maj       = (s0 & s1) | (s0 & rs) | (s1 & rs);
  assign dec       = (cnt == C_DEC);
  assign wrap      = (cnt == C_LAST);
  assign last_data = (idx == IW'(WIDTH - 1));
  assign last_stop = (idx == IW'(STOPS - 1));
  assign fe_f      = fe_acc | ~maj;
  assign zero_f    = zero_acc & ~maj;

  // Register all state, datapath and outputs; rx enters via a 2-flop synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_meta    <= 1'b1;
      rs         <= 1'b1;
      state      <= HUNT;
      cnt        <= '0;
      idx        <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      zero_acc   <= 1'b0;
      fe_acc     <= 1'b0;
      par_bad    <= 1'b0;
      out        <= '0;
      put        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      brk        <= 1'b0;
      rts        <= 1'b1;
    end else begin
      rs_meta    <= rx;
      rs         <= rs_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      s0         <= s0_n;
      s1         <= s1_n;
      shreg      <= shreg_n;
      zero_acc   <= zero_acc_n;
      fe_acc     <= fe_acc_n;
      par_bad    <= par_bad_n;
      out        <= out_n;
      put        <= put_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
      brk        <= brk_n;
      rts        <= rts_n;
    end
  end

  // Next-state and next-output logic for the frame receiver.
  always_comb begin
    state_n      = state;
    cnt_n        = wrap ? '0 : cnt + CW'(1);
    idx_n        = idx;
    s0_n         = (cnt == C_S0) ? rs : s0;
    s1_n         = (cnt == C_S1) ? rs : s1;
    shreg_n      = shreg;
    zero_acc_n   = zero_acc;
    fe_acc_n     = fe_acc;
    par_bad_n    = par_bad;
    out_n        = out;
    put_n        = 1'b0;
    frame_err_n  = frame_err;
    parity_err_n = parity_err;
    brk_n        = 1'b0;

    case (state)
      HUNT: begin
        if (!rs) begin
          cnt_n = '0;
        end else if (cnt == C_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (!rs) begin
          state_n    = START;
          idx_n      = '0;
          zero_acc_n = 1'b1;
          fe_acc_n   = 1'b0;
          par_bad_n  = 1'b0;
        end
      end
      START: begin
        if (dec && maj) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (wrap) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (dec) begin
          shreg_n    = {maj, shreg[WIDTH-1:1]};
          zero_acc_n = zero_f;
        end
        if (wrap) begin
          if (last_data) begin
            state_n = (PARITY != 0) ? PAR : STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PAR: begin
        if (dec) begin
          par_bad_n  = (PARITY == 2) ? ~(^shreg ^ maj) : (^shreg ^ maj);
          zero_acc_n = zero_f;
        end
        if (wrap) begin
          state_n = STOP;
          idx_n   = '0;
        end
      end
      STOP: begin
        if (dec) begin
          fe_acc_n   = fe_f;
          zero_acc_n = zero_f;
        end
        if (dec && last_stop) begin
          cnt_n = '0;
          if (zero_f) begin
            brk_n   = 1'b1;
            state_n = HUNT;
          end else begin
            put_n        = 1'b1;
            out_n        = shreg;
            frame_err_n  = fe_f;
            parity_err_n = par_bad;
            state_n      = fe_f ? HUNT : IDLE;
          end
        end else if (wrap) begin
          idx_n = idx + IW'(1);
        end
      end
      default: begin
        state_n = HUNT;
        cnt_n   = '0;
      end
    endcase

    rts_n = (state_n == HUNT);
  end

endmodule
